// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage.
// Registers the MEM/WB bundle and drives the register-file write port.
// It also rebuilds 32-bit PC values that arrive as two stack words
// (high half first) and issues one PC load to fetch.
// Optional feature: define WB_RETIRE_CNT_EN to add the retire_count output.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no PC pair in progress
// HALF  | high half of the PC is stored; waiting for the low half
module writeback_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int PC_W       = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wb_in_valid,
    input  logic [2*DATA_W+2*REG_ADDR_W+3:0]   wb_input,
    input  logic                               stall,
    input  logic                               flush,
    output logic                               reg_write_en,
    output logic [REG_ADDR_W-1:0]              reg_write_addr,
    output logic [DATA_W-1:0]                  reg_write_data,
    output logic                               pc_load_valid,
    output logic [PC_W-1:0]                    pc_load_value,
    output logic                               pc_seq_err,
`ifdef WB_RETIRE_CNT_EN
    output logic                               pc_pending,
    output logic [31:0]                        retire_count
`else
    output logic                               pc_pending
`endif
);

    localparam int IN_W = 2*DATA_W + 2*REG_ADDR_W + 4;

    localparam logic [1:0] CTRL_ALU = 2'b01;
    localparam logic [1:0] CTRL_MEM = 2'b10;
    localparam logic [1:0] CTRL_PC  = 2'b11;

    typedef enum logic {IDLE, HALF} state_t;

    state_t                  state;
    logic [DATA_W-1:0]       pc_hi;

    logic [DATA_W-1:0]       mem_data;
    logic [DATA_W-1:0]       alu_data;
    logic [REG_ADDR_W-1:0]   rdst;
    logic [REG_ADDR_W-1:0]   rsrc;
    logic [1:0]              stack_op;
    logic [1:0]              wb_ctrl;
    logic                    accept;
    logic                    unused_fields;

    assign mem_data = wb_input[IN_W-1 -: DATA_W];
    assign alu_data = wb_input[2*REG_ADDR_W+4 +: DATA_W];
    assign rdst     = wb_input[REG_ADDR_W+4 +: REG_ADDR_W];
    assign rsrc     = wb_input[4 +: REG_ADDR_W];
    assign stack_op = wb_input[3:2];
    assign wb_ctrl  = wb_input[1:0];

    // rsrc and stack_op travel with the instruction but are not needed here
    assign unused_fields = ^{rsrc, stack_op};

    assign accept = wb_in_valid & ~stall & ~flush;

    // Register-write decode, PC pair sequencing and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc_hi          <= '0;
            reg_write_en   <= 1'b0;
            reg_write_addr <= '0;
            reg_write_data <= '0;
            pc_load_valid  <= 1'b0;
            pc_load_value  <= '0;
            pc_seq_err     <= 1'b0;
            pc_pending     <= 1'b0;
        end else begin
            // strobes are single-cycle; stall leaves data outputs holding
            reg_write_en  <= 1'b0;
            pc_load_valid <= 1'b0;
            pc_seq_err    <= 1'b0;
            if (flush) begin
                state      <= IDLE;
                pc_hi      <= '0;
                pc_pending <= 1'b0;
            end else if (accept) begin
                case (wb_ctrl)
                    CTRL_ALU: begin
                        reg_write_en   <= 1'b1;
                        reg_write_addr <= rdst;
                        reg_write_data <= alu_data;
                    end
                    CTRL_MEM: begin
                        reg_write_en   <= 1'b1;
                        reg_write_addr <= rdst;
                        reg_write_data <= mem_data;
                    end
                    default: ;
                endcase
                if (wb_ctrl == CTRL_PC) begin
                    if (state == IDLE) begin
                        pc_hi      <= mem_data;
                        state      <= HALF;
                        pc_pending <= 1'b1;
                    end else begin
                        pc_load_value <= {pc_hi, mem_data};
                        pc_load_valid <= 1'b1;
                        pc_hi         <= '0;
                        state         <= IDLE;
                        pc_pending    <= 1'b0;
                    end
                end else if (state == HALF) begin
                    // pair broken by an ordinary instruction: drop the high half
                    pc_seq_err <= 1'b1;
                    pc_hi      <= '0;
                    state      <= IDLE;
                    pc_pending <= 1'b0;
                end
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Count retired instructions; a PC pair retires once, on its low half
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count <= '0;
        end else if (accept && !(state == IDLE && wb_ctrl == CTRL_PC)) begin
            retire_count <= retire_count + 32'd1;
        end
    end
`endif

endmodule
